// File: rtl/led_flow.sv
// -----------------------------------------------------------------------------
// led_flow
//   Running-light driver for the board LED bank. A free-running step timer
//   divides sys_clk down to a visible step rate; on every step a single lit
//   LED moves one position across the bank, either rotating toward the MSB
//   with wrap-around (MODE 0) or bouncing between the two ends (MODE 1).
//
// Parameters
//   CNT_MAX  sys_clk cycles per LED step (>= 1)
//   LED_W    number of LEDs (>= 2)
//   MODE     0 = rotate toward MSB with wrap, 1 = ping-pong
//
// Ports
//   sys_clk  in   1      system clock, all logic on the rising edge
//   sys_rst  in   1      synchronous reset, active-high
//   led      out  LED_W  LED drive, 1 = lit, registered, one-hot after reset
// -----------------------------------------------------------------------------
module led_flow #(
    parameter int CNT_MAX = 25_000_000,
    parameter int LED_W   = 4,
    parameter int MODE    = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    output logic [LED_W-1:0] led
);

    // A one-count timer still needs a 1-bit register; it simply sits at 0
    // and produces a step every cycle.
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [CNT_W-1:0] cnt;
    logic             step;
    logic             dir;      // 1 = moving toward the MSB
    logic [LED_W-1:0] led_nxt;
    logic             dir_nxt;

    assign step = (cnt == CNT_W'(CNT_MAX - 1));

    // Position/direction for the next step. In ping-pong mode the reversal
    // and the move away from the end happen on the same step, so the end
    // LED is never shown twice in a row.
    always_comb begin
        led_nxt = led;
        dir_nxt = dir;
        if (MODE == 0) begin
            led_nxt = {led[LED_W-2:0], led[LED_W-1]};
        end else if (dir) begin
            if (led[LED_W-1]) begin
                dir_nxt = 1'b0;
                led_nxt = led >> 1;
            end else begin
                led_nxt = led << 1;
            end
        end else begin
            if (led[0]) begin
                dir_nxt = 1'b1;
                led_nxt = led << 1;
            end else begin
                led_nxt = led >> 1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt <= '0;
            led <= LED_W'(1);
            dir <= 1'b1;
        end else if (step) begin
            // Counter wraps on the same edge that consumes the step, so
            // step spacing is exactly CNT_MAX edges with no drift.
            cnt <= '0;
            led <= led_nxt;
            dir <= dir_nxt;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_led_flow.sv
// -----------------------------------------------------------------------------
// tb_led_flow
//   Three led_flow instances run side by side, each with its own reset:
//     u0: CNT_MAX=5, MODE 0  (rotation, 1-cycle and held mid-sequence resets)
//     u1: CNT_MAX=5, MODE 1  (ping-pong over ten steps)
//     u2: CNT_MAX=1, MODE 0  (a step on every edge)
//   Every expected LED change (edge number and new value) is queued up front
//   from hand-written tables; a monitor on the falling edge pops an entry each
//   time an LED bank changes and compares it, and checks one-hotness each
//   cycle after the first reset edge.
// -----------------------------------------------------------------------------
module tb_led_flow;

    typedef struct {
        int         at;
        logic [3:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1;
    logic       rst1 = 1'b1;
    logic       rst2 = 1'b1;
    logic [3:0] led0, led1, led2;

    int         edge_n = 0;
    int         checks = 0;
    int         fails  = 0;
    exp_t       q [3][$];
    logic [3:0] prev [3];
    logic [3:0] cur  [3];
    exp_t       e;

    always #5 clk = ~clk;

    always @(posedge clk) edge_n++;

    led_flow #(.CNT_MAX(5), .LED_W(4), .MODE(0)) u0 (
        .sys_clk(clk), .sys_rst(rst0), .led(led0));
    led_flow #(.CNT_MAX(5), .LED_W(4), .MODE(1)) u1 (
        .sys_clk(clk), .sys_rst(rst1), .led(led1));
    led_flow #(.CNT_MAX(1), .LED_W(4), .MODE(0)) u2 (
        .sys_clk(clk), .sys_rst(rst2), .led(led2));

    function automatic void push(input int i, input int at, input logic [3:0] v);
        exp_t x;
        x.at  = at;
        x.val = v;
        q[i].push_back(x);
    endfunction

    // Monitor: every LED change must match the head of that instance's queue.
    always @(negedge clk) begin
        cur[0] = led0;
        cur[1] = led1;
        cur[2] = led2;
        for (int i = 0; i < 3; i++) begin
            if (cur[i] !== prev[i]) begin
                checks++;
                if (q[i].size() == 0) begin
                    fails++;
                    $display("FAIL change_u%0d: led=%b at edge %0d, required no change", i, cur[i], edge_n);
                end else begin
                    e = q[i].pop_front();
                    if (e.at != edge_n || e.val !== cur[i]) begin
                        fails++;
                        $display("FAIL change_u%0d: led=%b at edge %0d, required led=%b at edge %0d",
                                 i, cur[i], edge_n, e.val, e.at);
                    end
                end
                prev[i] = cur[i];
            end
            if (edge_n >= 1) begin
                checks++;
                if (!$onehot(cur[i])) begin
                    fails++;
                    $display("FAIL onehot_u%0d: led=%b at edge %0d, required one-hot", i, cur[i], edge_n);
                end
            end
        end
    end

    // Hold until the falling edge that follows rising edge n.
    task automatic to_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] rot [4];
        logic [3:0] pp  [10];
        rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        pp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
        for (int i = 0; i < 3; i++) prev[i] = 4'bxxxx;

        // u0: reset edges 1..10, steps every 5 edges from edge 15.
        push(0, 1, 4'b0001);
        for (int k = 0; k < 6; k++) push(0, 15 + 5 * k, rot[k % 4]);
        // 1-cycle reset at edge 44 (led=0100, counter=3): next step 5 edges on.
        push(0, 44, 4'b0001);
        push(0, 49, 4'b0010);
        push(0, 54, 4'b0100);
        push(0, 59, 4'b1000);
        // Reset held over edges 62..81: no stepping while held.
        push(0, 62, 4'b0001);
        push(0, 86, 4'b0010);
        push(0, 91, 4'b0100);
        push(0, 93, 4'b0001);

        // u1: ping-pong, ten steps from edge 15, then reset at edge 63.
        push(1, 1, 4'b0001);
        for (int k = 0; k < 10; k++) push(1, 15 + 5 * k, pp[k]);
        push(1, 63, 4'b0001);

        // u2: step every edge from edge 11, reset at edge 21, then four steps.
        push(2, 1, 4'b0001);
        for (int k = 0; k < 10; k++) push(2, 11 + k, rot[k % 4]);
        push(2, 21, 4'b0001);
        for (int k = 0; k < 4; k++) push(2, 22 + k, rot[k]);

        to_edge(10);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        to_edge(20); rst2 = 1'b1;
        to_edge(21); rst2 = 1'b0;
        to_edge(25); rst2 = 1'b1;
        to_edge(43); rst0 = 1'b1;
        to_edge(44); rst0 = 1'b0;
        to_edge(61); rst0 = 1'b1;
        to_edge(62); rst1 = 1'b1;
        to_edge(81); rst0 = 1'b0;
        to_edge(92); rst0 = 1'b1;
        to_edge(120);

        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                fails++;
                $display("FAIL pending_u%0d: %0d expected changes never seen, required 0", i, q[i].size());
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
